// File: rtl/encoder_pkg.sv
// Shared constants and state type for the 16:4 sequential index encoder.
package encoder_pkg;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned IDX_W = $clog2(WIDTH);
    localparam int unsigned CNT_W = IDX_W + 1;

    typedef enum logic {
        IDLE,
        SCAN
    } enc_state_t;

endpackage

// File: rtl/sixteen_to_four_seq_encoder_lsb_priority_enc.sv
// Combinational lowest-set-bit finder: reports whether any bit is set and its index.
module lsb_priority_enc #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    // Scan from the top down so the lowest set bit is the last to overwrite idx.
    always_comb begin
        any = |vec;
        idx = '0;
        for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/sixteen_to_four_seq_encoder.sv
// Multi-hot to binary index streamer: one index beat per set bit of an accepted
// vector, lowest first; an all-zero vector yields a single "none" beat.
module sixteen_to_four_seq_encoder #(
    parameter int unsigned WIDTH = encoder_pkg::WIDTH,
    parameter int unsigned IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] f_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [IDX_W-1:0] idx,
    output logic             none,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic [IDX_W:0]   out_count
);

    import encoder_pkg::*;

    enc_state_t       state;
    enc_state_t       state_next;
    logic [WIDTH-1:0] pending;
    logic [WIDTH-1:0] clr_mask;
    logic [IDX_W:0]   count;
    logic [IDX_W-1:0] low_idx;
    logic             low_any;
    logic             single;
    logic             scanning;
    logic             accept;
    logic             beat;

    lsb_priority_enc #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_lsb (
        .vec (pending),
        .any (low_any),
        .idx (low_idx)
    );

    // At most one bit left (also true for zero), so the current beat is the last.
    assign single   = ((pending & (pending - WIDTH'(1))) == '0);
    assign clr_mask = WIDTH'(1) << low_idx;
    assign scanning = (state == SCAN);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and handshake decode; en low blocks both accept and beat.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        beat       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = en & ~rst;
                accept   = in_valid & en & ~rst;
                if (accept) begin
                    state_next = SCAN;
                end
            end
            SCAN: begin
                out_valid = en;
                beat      = en & out_ready;
                if (beat && single) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Pending bits and beat counter; both hold unless accepting or transferring.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
            count   <= '0;
        end else if (accept) begin
            pending <= f_in;
            count   <= '0;
        end else if (beat) begin
            pending <= pending & ~clr_mask;
            count   <= count + (IDX_W + 1)'(1);
        end
    end

    // Beat payload is derived purely from registered state.
    assign idx       = scanning ? low_idx : '0;
    assign none      = scanning & ~low_any;
    assign out_last  = scanning & single;
    assign out_count = count;

endmodule

// File: tb/tb_sixteen_to_four_seq_encoder.sv
// Bench for sixteen_to_four_seq_encoder: directed scenarios plus randomized
// vectors, checked against an index-queue reference model.
module tb_sixteen_to_four_seq_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] f_in;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  idx;
    logic        none;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic [4:0]  out_count;

    int n_checks = 0;
    int n_fail   = 0;

    sixteen_to_four_seq_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .f_in      (f_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .idx       (idx),
        .none      (none),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at negedge+1 with the block idle. Model: queue of set-bit positions.
    task automatic run_vector(input logic [15:0] vec, input int hold,
                              input int en_drop_at, input bit rnd);
        int q[$];
        int k;
        int guard;
        int en_low_left;
        bit dropped;
        bit zero;
        for (int i = 0; i < 16; i++) begin
            if (vec[i]) q.push_back(i);
        end
        zero = (q.size() == 0);
        if (zero) q.push_back(0);

        en = 1'b1;
        #1;
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        f_in     = vec;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        f_in     = 16'($urandom);

        k = 0;
        guard = 0;
        en_low_left = 0;
        dropped = 1'b0;
        while (q.size() > 0 && guard < 400) begin
            if (en_drop_at >= 0 && k == en_drop_at && !dropped) begin
                en_low_left = 2;
                dropped = 1'b1;
            end
            if (en_low_left > 0) begin
                en = 1'b0;
                en_low_left--;
            end else begin
                en = rnd ? ($urandom_range(0, 7) != 0) : 1'b1;
            end
            out_ready = (guard < hold) ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
            #1;
            chk("out_valid", 32'(out_valid), 32'(en));
            chk("idx",       32'(idx),       32'(q[0]));
            chk("none",      32'(none),      32'(zero));
            chk("out_last",  32'(out_last),  32'(q.size() == 1));
            chk("out_count", 32'(out_count), 32'(k));
            chk("in_ready_scan", 32'(in_ready), 32'd0);
            if (en && out_ready) begin
                void'(q.pop_front());
                k++;
            end
            guard++;
            @(negedge clk);
        end
        if (guard >= 400) chk("scan_timeout", 32'd0, 32'd1);

        en = 1'b1;
        out_ready = 1'b0;
        #1;
        chk("in_ready_after", 32'(in_ready),  32'd1);
        chk("valid_after",    32'(out_valid), 32'd0);
        chk("count_final",    32'(out_count), 32'(k));
    endtask

    initial begin
        rst       = 1'b1;
        en        = 1'b0;
        f_in      = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;

        @(negedge clk);
        en = 1'b1;
        #1;
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_idx",       32'(idx),       32'd0);
        chk("rst_none",      32'(none),      32'd0);
        chk("rst_last",      32'(out_last),  32'd0);
        chk("rst_count",     32'(out_count), 32'd0);

        @(negedge clk);
        rst = 1'b0;
        en  = 1'b0;
        #1;
        chk("idle_en_low", 32'(in_ready), 32'd0);

        run_vector(16'h0001, 0, -1, 1'b0);
        run_vector(16'h8421, 0, -1, 1'b0);
        run_vector(16'h0006, 3, -1, 1'b0);
        run_vector(16'h0000, 0, -1, 1'b0);
        run_vector(16'hFFFF, 0, 4, 1'b0);

        // Reset in the middle of a scan discards the remaining bits.
        f_in     = 16'hF0F0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("mid_idx0", 32'(idx), 32'd4);
        @(negedge clk);
        #1;
        chk("mid_idx1",   32'(idx),       32'd5);
        chk("mid_count1", 32'(out_count), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_count", 32'(out_count), 32'd0);
        chk("mid_rst_ready", 32'(in_ready),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("post_rst_ready", 32'(in_ready),  32'd1);
        chk("post_rst_valid", 32'(out_valid), 32'd0);
        run_vector(16'h0100, 0, -1, 1'b0);

        for (int n = 0; n < 25; n++) begin
            logic [15:0] v;
            v = 16'($urandom);
            if (n % 3 == 1) v = v & 16'($urandom) & 16'($urandom);
            if (n % 8 == 5) v = 16'h0000;
            run_vector(v, int'($urandom_range(0, 2)), -1, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
